// File: rtl/bus_pkg.sv
// Shared bus widths and the responder FSM state type for the bus_sram_resp slice.
package bus_pkg;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 4;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [DATA_W-1:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RD      = 2'd3
  } state_e;
endpackage

// File: rtl/bus_sram_mem.sv
// Word storage with one byte-enabled write port and one synchronous read port.
module bus_sram_mem
  import bus_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**AW];

  // NOTE: the array has no reset so it maps onto RAM; o_rdata is masked by the FSM until valid.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/bus_sram_resp.sv
// Single-transaction burst SRAM responder. Optional out-of-range address check
// enabled by defining BUS_SRAM_RESP_ADDR_CHECK_EN.
module bus_sram_resp
  import bus_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] BusSr_awaddr,
  input  logic              BusSr_awuserap,
  input  logic [ID_W-1:0]   BusSr_awuserid,
  input  logic [LEN_W-1:0]  BusSr_awlen,
  input  logic              BusSr_awvalid,
  output logic              SrBus_awready,
  input  logic [ADDR_W-1:0] BusSr_araddr,
  input  logic              BusSr_aruserap,
  input  logic [ID_W-1:0]   BusSr_aruserid,
  input  logic [LEN_W-1:0]  BusSr_arlen,
  input  logic              BusSr_arvalid,
  output logic              SrBus_arready,
  input  logic [DATA_W-1:0] BusSr_wdata,
  input  logic [STRB_W-1:0] BusSr_wstrb,
  input  logic              BusSr_wvalid,
  output logic              SrBus_wready,
  output logic [ID_W-1:0]   SrBus_wuserid,
  output logic              SrBus_wlast,
  output logic [DATA_W-1:0] SrBus_rdata,
  output logic [ID_W-1:0]   SrBus_rid,
  output logic              SrBus_rvalid,
  output logic              SrBus_rlast
);

  state_e              r_state, w_next;
  logic [MEM_AW-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_beat;
  logic [ID_W-1:0]     r_id;
  logic                w_last;
  logic                w_we;
  logic [DATA_W-1:0]   w_mem_rdata;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_unused;

  assign w_last   = (r_beat == r_len);
  assign w_unused = ^{BusSr_awuserap, BusSr_aruserap,
                      BusSr_awaddr[ADDR_W-1:MEM_AW], BusSr_araddr[ADDR_W-1:MEM_AW]};

`ifdef BUS_SRAM_RESP_ADDR_CHECK_EN
  logic r_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad <= 1'b0;
    end else if (r_state == IDLE) begin
      if (BusSr_awvalid)      r_bad <= |BusSr_awaddr[ADDR_W-1:MEM_AW];
      else if (BusSr_arvalid) r_bad <= |BusSr_araddr[ADDR_W-1:MEM_AW];
    end
  end

  assign w_we      = (r_state == WR) && BusSr_wvalid && !r_bad;
  assign w_rd_word = r_bad ? BAD_ADDR_DATA : w_mem_rdata;
`else
  assign w_we      = (r_state == WR) && BusSr_wvalid;
  assign w_rd_word = w_mem_rdata;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Read address runs one word ahead of the beat on the bus to cover the RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_len  <= '0;
      r_beat <= '0;
      r_id   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beat <= '0;
          if (BusSr_awvalid) begin
            r_addr <= BusSr_awaddr[MEM_AW-1:0];
            r_len  <= BusSr_awlen;
            r_id   <= BusSr_awuserid;
          end else if (BusSr_arvalid) begin
            r_addr <= BusSr_araddr[MEM_AW-1:0];
            r_len  <= BusSr_arlen;
            r_id   <= BusSr_aruserid;
          end
        end
        WR: begin
          if (BusSr_wvalid) begin
            r_addr <= r_addr + 1'b1;
            r_beat <= r_beat + 1'b1;
          end
        end
        RD_WAIT: r_addr <= r_addr + 1'b1;
        RD: begin
          r_addr <= r_addr + 1'b1;
          r_beat <= r_beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output and w_next gets a default first so no latch is inferred.
  always_comb begin
    w_next        = r_state;
    SrBus_awready = 1'b0;
    SrBus_arready = 1'b0;
    SrBus_wready  = 1'b0;
    SrBus_wuserid = '0;
    SrBus_wlast   = 1'b0;
    SrBus_rdata   = '0;
    SrBus_rid     = '0;
    SrBus_rvalid  = 1'b0;
    SrBus_rlast   = 1'b0;
    case (r_state)
      IDLE: begin
        // Ready is qualified by rst_n so it stays low while reset is held.
        if (BusSr_awvalid) begin
          SrBus_awready = rst_n;
          w_next        = WR;
        end else if (BusSr_arvalid) begin
          SrBus_arready = rst_n;
          w_next        = RD_WAIT;
        end
      end
      WR: begin
        SrBus_wready  = 1'b1;
        SrBus_wuserid = r_id;
        SrBus_wlast   = w_last;
        if (BusSr_wvalid && w_last) w_next = IDLE;
      end
      RD_WAIT: w_next = RD;
      RD: begin
        SrBus_rvalid = 1'b1;
        SrBus_rid    = r_id;
        SrBus_rlast  = w_last;
        SrBus_rdata  = w_rd_word;
        if (w_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  bus_sram_mem #(.AW(MEM_AW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (BusSr_wdata),
    .i_wstrb (BusSr_wstrb),
    .i_raddr (r_addr),
    .o_rdata (w_mem_rdata)
  );

endmodule

// File: tb/tb_bus_sram_resp.sv
// Directed self-checking bench for bus_sram_resp (MEM_AW = 8).
module tb_bus_sram_resp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] BusSr_awaddr;
  logic        BusSr_awuserap;
  logic [3:0]  BusSr_awuserid;
  logic [3:0]  BusSr_awlen;
  logic        BusSr_awvalid;
  logic        SrBus_awready;
  logic [27:0] BusSr_araddr;
  logic        BusSr_aruserap;
  logic [3:0]  BusSr_aruserid;
  logic [3:0]  BusSr_arlen;
  logic        BusSr_arvalid;
  logic        SrBus_arready;
  logic [31:0] BusSr_wdata;
  logic [3:0]  BusSr_wstrb;
  logic        BusSr_wvalid;
  logic        SrBus_wready;
  logic [3:0]  SrBus_wuserid;
  logic        SrBus_wlast;
  logic [31:0] SrBus_rdata;
  logic [3:0]  SrBus_rid;
  logic        SrBus_rvalid;
  logic        SrBus_rlast;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] wd [16];
  logic [31:0] re [16];

  always #5 clk = ~clk;

  bus_sram_resp #(.MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .BusSr_awaddr(BusSr_awaddr), .BusSr_awuserap(BusSr_awuserap),
    .BusSr_awuserid(BusSr_awuserid), .BusSr_awlen(BusSr_awlen),
    .BusSr_awvalid(BusSr_awvalid), .SrBus_awready(SrBus_awready),
    .BusSr_araddr(BusSr_araddr), .BusSr_aruserap(BusSr_aruserap),
    .BusSr_aruserid(BusSr_aruserid), .BusSr_arlen(BusSr_arlen),
    .BusSr_arvalid(BusSr_arvalid), .SrBus_arready(SrBus_arready),
    .BusSr_wdata(BusSr_wdata), .BusSr_wstrb(BusSr_wstrb),
    .BusSr_wvalid(BusSr_wvalid), .SrBus_wready(SrBus_wready),
    .SrBus_wuserid(SrBus_wuserid), .SrBus_wlast(SrBus_wlast),
    .SrBus_rdata(SrBus_rdata), .SrBus_rid(SrBus_rid),
    .SrBus_rvalid(SrBus_rvalid), .SrBus_rlast(SrBus_rlast)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input logic [27:0] addr, input logic [3:0] id,
                             input logic [3:0] len, input logic [3:0] strb);
    BusSr_awaddr   = addr;
    BusSr_awuserid = id;
    BusSr_awlen    = len;
    BusSr_awvalid  = 1'b1;
    #1 check("awready", {31'b0, SrBus_awready}, 32'd1);
    tick();
    BusSr_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      BusSr_wvalid = 1'b1;
      BusSr_wdata  = wd[i];
      BusSr_wstrb  = strb;
      #1;
      check("wready", {31'b0, SrBus_wready}, 32'd1);
      check("wlast", {31'b0, SrBus_wlast}, (i == int'(len)) ? 32'd1 : 32'd0);
      check("wuserid", {28'b0, SrBus_wuserid}, {28'b0, id});
      tick();
    end
    BusSr_wvalid = 1'b0;
    #1 check("wready_idle", {31'b0, SrBus_wready}, 32'd0);
    tick();
  endtask

  task automatic read_burst(input logic [27:0] addr, input logic [3:0] id, input logic [3:0] len);
    BusSr_araddr   = addr;
    BusSr_aruserid = id;
    BusSr_arlen    = len;
    BusSr_arvalid  = 1'b1;
    #1 check("arready", {31'b0, SrBus_arready}, 32'd1);
    tick();
    BusSr_arvalid = 1'b0;
    #1 check("rvalid_wait", {31'b0, SrBus_rvalid}, 32'd0);
    tick();
    for (int i = 0; i <= int'(len); i++) begin
      check("rvalid", {31'b0, SrBus_rvalid}, 32'd1);
      check("rdata", SrBus_rdata, re[i]);
      check("rid", {28'b0, SrBus_rid}, {28'b0, id});
      check("rlast", {31'b0, SrBus_rlast}, (i == int'(len)) ? 32'd1 : 32'd0);
      tick();
    end
    check("rvalid_after", {31'b0, SrBus_rvalid}, 32'd0);
    check("rdata_after", SrBus_rdata, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    BusSr_awaddr = '0; BusSr_awuserap = 1'b0; BusSr_awuserid = '0; BusSr_awlen = '0;
    BusSr_araddr = '0; BusSr_aruserap = 1'b0; BusSr_aruserid = '0; BusSr_arlen = '0;
    BusSr_wdata = '0; BusSr_wstrb = '0; BusSr_wvalid = 1'b0;
    BusSr_awvalid = 1'b1;
    BusSr_arvalid = 1'b1;
    #2;
    check("rst_awready", {31'b0, SrBus_awready}, 32'd0);
    check("rst_arready", {31'b0, SrBus_arready}, 32'd0);
    check("rst_rvalid", {31'b0, SrBus_rvalid}, 32'd0);
    check("rst_wready", {31'b0, SrBus_wready}, 32'd0);
    tick(); tick();
    BusSr_awvalid = 1'b0;
    BusSr_arvalid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single beat write and read back
    wd[0] = 32'h1234_5678;
    write_burst(28'h10, 4'hB, 4'd0, 4'hF);
    re[0] = 32'h1234_5678;
    read_burst(28'h10, 4'hB, 4'd0);

    // Four beats wrapping past the top of memory
    wd[0] = 32'hA0A0_0001; wd[1] = 32'hA0A0_0002; wd[2] = 32'hA0A0_0003; wd[3] = 32'hA0A0_0004;
    write_burst(28'hFE, 4'h2, 4'd3, 4'hF);
    re[0] = 32'hA0A0_0001; re[1] = 32'hA0A0_0002; re[2] = 32'hA0A0_0003; re[3] = 32'hA0A0_0004;
    read_burst(28'hFE, 4'h7, 4'd3);
    re[0] = 32'hA0A0_0003;
    read_burst(28'h00, 4'h1, 4'd0);

    // Partial byte strobes
    wd[0] = 32'hFFFF_FFFF;
    write_burst(28'h20, 4'h4, 4'd0, 4'hF);
    wd[0] = 32'h0000_0000;
    write_burst(28'h20, 4'h4, 4'd0, 4'h5);
    re[0] = 32'hFF00_FF00;
    read_burst(28'h20, 4'h4, 4'd0);

    // Maximum-length burst
    for (int i = 0; i < 16; i++) begin
      wd[i] = 32'h1000_0000 + i;
      re[i] = 32'h1000_0000 + i;
    end
    write_burst(28'h40, 4'h9, 4'd15, 4'hF);
    read_burst(28'h40, 4'hA, 4'd15);

    // Simultaneous aw and ar: write first, read sees new data
    BusSr_awaddr = 28'h30; BusSr_awuserid = 4'h3; BusSr_awlen = 4'd0; BusSr_awvalid = 1'b1;
    BusSr_araddr = 28'h30; BusSr_aruserid = 4'h5; BusSr_arlen = 4'd0; BusSr_arvalid = 1'b1;
    #1;
    check("both_awready", {31'b0, SrBus_awready}, 32'd1);
    check("both_arready", {31'b0, SrBus_arready}, 32'd0);
    tick();
    BusSr_awvalid = 1'b0;
    BusSr_wvalid = 1'b1; BusSr_wdata = 32'hCAFE_F00D; BusSr_wstrb = 4'hF;
    #1;
    check("both_wr_arready", {31'b0, SrBus_arready}, 32'd0);
    check("both_wlast", {31'b0, SrBus_wlast}, 32'd1);
    tick();
    BusSr_wvalid = 1'b0;
    #1 check("both_pending_arready", {31'b0, SrBus_arready}, 32'd1);
    tick();
    BusSr_arvalid = 1'b0;
    tick();
    check("both_rvalid", {31'b0, SrBus_rvalid}, 32'd1);
    check("both_rdata", SrBus_rdata, 32'hCAFE_F00D);
    check("both_rid", {28'b0, SrBus_rid}, 32'h5);
    tick();

    // Reset in the middle of an 8-beat read
    BusSr_araddr = 28'hFE; BusSr_aruserid = 4'h6; BusSr_arlen = 4'd7; BusSr_arvalid = 1'b1;
    tick();
    BusSr_arvalid = 1'b0;
    tick();
    check("mid_b0", SrBus_rdata, 32'hA0A0_0001);
    tick();
    check("mid_b1", SrBus_rdata, 32'hA0A0_0002);
    check("mid_b1_valid", {31'b0, SrBus_rvalid}, 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", {31'b0, SrBus_rvalid}, 32'd0);
    check("mid_rst_rdata", SrBus_rdata, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_rvalid", {31'b0, SrBus_rvalid}, 32'd0);
      check("post_rst_wready", {31'b0, SrBus_wready}, 32'd0);
    end
    re[0] = 32'h1234_5678;
    read_burst(28'h10, 4'hC, 4'd0);

    // Out-of-range address
    wd[0] = 32'h1111_2222;
    write_burst(28'h100, 4'h8, 4'd0, 4'hF);
`ifdef BUS_SRAM_RESP_ADDR_CHECK_EN
    re[0] = 32'hA0A0_0003;
    read_burst(28'h00, 4'h8, 4'd0);
    re[0] = 32'hDEAD_BEEF;
    read_burst(28'h100, 4'h8, 4'd0);
`else
    re[0] = 32'h1111_2222;
    read_burst(28'h00, 4'h8, 4'd0);
    read_burst(28'h100, 4'h8, 4'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_sram_resp.md
BUS_SRAM_RESP -- requirements
Module: bus_sram_resp

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 8, meaning word-address width of internal storage (depth 2**MEM_AW words of 32 bits).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named exactly clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 BusSr_awaddr  input  28  write word address; BusSr_awuserap  input  1  user flag, ignored; BusSr_awuserid  input  4  write ID; BusSr_awlen  input  4  beats minus one; BusSr_awvalid  input  1  request valid.
REQ-006 SrBus_awready  output  1  write-address accept.
REQ-007 BusSr_araddr  input  28; BusSr_aruserap  input  1, ignored; BusSr_aruserid  input  4; BusSr_arlen  input  4; BusSr_arvalid  input  1; these mirror the write-address fields for reads.
REQ-008 SrBus_arready  output  1  read-address accept.
REQ-009 BusSr_wdata  input  32; BusSr_wstrb  input  4  byte enables; BusSr_wvalid  input  1  beat valid.
REQ-010 SrBus_wready  output  1; SrBus_wuserid  output  4  ID of active write; SrBus_wlast  output  1  final beat expected.
REQ-011 SrBus_rdata  output  32; SrBus_rid  output  4; SrBus_rvalid  output  1; SrBus_rlast  output  1; the initiator SHALL always accept read beats (no rready).

Function
REQ-012 FSM states SHALL be IDLE, WR, RD_WAIT, RD; only one transaction is active at a time.
REQ-013 IDLE: awvalid high -> awready high for that cycle, latch awaddr[MEM_AW-1:0], awuserid, awlen, go WR; else arvalid high -> arready high one cycle, latch read fields, go RD_WAIT; both valid same cycle -> write wins, read stays pending.
REQ-014 awready/arready SHALL be high only in IDLE and only in the accept cycle.
REQ-015 WR: wready=1, wuserid=latched ID, wlast=1 when beat counter equals latched len; beat accepted when wready&&wvalid.
REQ-016 Accepted write beat SHALL update only bytes whose wstrb bit is 1; the address increments by 1 per beat and wraps modulo 2**MEM_AW.
REQ-017 After the beat with counter==len is accepted, the FSM SHALL return to IDLE next cycle; wvalid low holds WR with no update.
REQ-018 RD_WAIT lasts one cycle (synchronous storage read); RD then drives rvalid=1 for exactly len+1 consecutive cycles, first beat 2 cycles after the ar accept cycle.
REQ-019 In RD, rid=latched aruserid; rlast=1 only on the final beat; rdata=word at latched address+beat index, modulo 2**MEM_AW.
REQ-020 Outside RD, rvalid, rlast, rdata, rid SHALL be 0; outside WR, wready, wlast, wuserid SHALL be 0.
REQ-021 awlen/arlen=0 SHALL give a single beat; 15 SHALL give 16 beats.

Reset
REQ-022 rst_n low SHALL force IDLE and all outputs to 0 immediately; storage contents are not reset.
REQ-023 Reset mid-burst SHALL abandon the burst; already-written beats persist; no further beats after release until a new request.

Configuration
REQ-024 Macro BUS_SRAM_RESP_ADDR_CHECK_EN defined: request with any of addr[27:MEM_AW] nonzero is still accepted and sequenced normally, but its writes are dropped and its read beats return 32'hDEAD_BEEF.
REQ-025 Macro undefined: addr[27:MEM_AW] ignored (aliasing), no check logic present.

Structure
REQ-026 Shared package bus_pkg SHALL hold ID width 4, LEN width 4, bus address width 28, data width 32, and the FSM state enum.
REQ-027 Storage SHALL be sub-module bus_sram_mem: 1 write port with 4 byte enables, 1 synchronous read port.

Verification
REQ-028 aw addr=0x10,len=0,id=0xB; one beat wdata=0x12345678,wstrb=0xF -> wlast=1 on that beat; later ar addr=0x10,len=0 -> rdata=0x12345678, rid=0xB-as-requested, rlast=1, at T+2.
REQ-029 Write 4 beats from addr 0xFE (MEM_AW=8) -> data lands at 0xFE,0xFF,0x00,0x01; 4-beat read from 0xFE returns same order, rlast on beat 4 only.
REQ-030 Word 0x20=0xFFFFFFFF, write 0x00000000 with wstrb=0x5 -> read returns 0xFF00FF00.
REQ-031 awvalid and arvalid same cycle -> awready first, write completes, then arready, read sees new data.
REQ-032 rst_n low after beat 2 of 8-beat read -> rvalid 0 immediately, IDLE after release, no stray beats.
REQ-033 With BUS_SRAM_RESP_ADDR_CHECK_EN, write/read addr=0x100 (MEM_AW=8) -> word 0x00 unchanged, read returns 0xDEADBEEF; without macro, word 0x00 updated.
